axi4_shared_traffic_gen: RTL and testbench

- Upstream stimulus/check stage for the AXI4-shared SDRAM controller tester; drives its arw/w/b/r channels as a bus master.
- On `start`, writes NUM_BURSTS INCR bursts of a deterministic pattern from BASE_ADDR, then reads all of them back and compares.
- Reports done/pass and a saturating error count; used for on-board and simulation self-check of the SDRAM path.

---
 rtl/axi4_shared_pkg.sv | 23 ++
 rtl/axi4_pattern_gen.sv | 17 +
 rtl/axi4_shared_traffic_gen.sv | 203 ++++++++++++++++++++
 tb/tb_axi4_shared_traffic_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_shared_pkg.sv
// Shared AXI4 constants, traffic-generator FSM states and a saturating counter helper.
package axi4_shared_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_FIN
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_pattern_gen.sv
// Deterministic data pattern: seed plus zero-extended beat byte address.
// The writer and the read checker use the same instance, so both sides always agree.
module axi4_pattern_gen #(
  parameter int          ADDR_W = 25,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
  input  logic [ADDR_W-1:0] beat_addr,
  output logic [DATA_W-1:0] data
);

  // Pattern is pure arithmetic; the sum wraps at the data width.
  always_comb begin
    data = DATA_W'(SEED) + DATA_W'(beat_addr);
  end

endmodule

// File: rtl/axi4_shared_traffic_gen.sv
// AXI4-shared traffic generator: writes NUM_BURSTS INCR bursts of a known
// pattern, reads them back, and counts every protocol or data error it sees.
module axi4_shared_traffic_gen
  import axi4_shared_pkg::*;
#(
  parameter int                ADDR_W     = 25,
  parameter int                DATA_W     = 32,
  parameter int                ID_W       = 2,
  parameter logic [ID_W-1:0]   ID         = '0,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                BURST_LEN  = 8,
  parameter int                NUM_BURSTS = 4,
  parameter logic [31:0]       SEED       = 32'hA5A5_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic              io_axi_arw_valid,
  input  logic              io_axi_arw_ready,
  output logic [ADDR_W-1:0] io_axi_arw_payload_addr,
  output logic [ID_W-1:0]   io_axi_arw_payload_id,
  output logic [7:0]        io_axi_arw_payload_len,
  output logic [2:0]        io_axi_arw_payload_size,
  output logic [1:0]        io_axi_arw_payload_burst,
  output logic              io_axi_arw_payload_write,
  output logic              io_axi_w_valid,
  input  logic              io_axi_w_ready,
  output logic [DATA_W-1:0] io_axi_w_payload_data,
  output logic [3:0]        io_axi_w_payload_strb,
  output logic              io_axi_w_payload_last,
  input  logic              io_axi_b_valid,
  output logic              io_axi_b_ready,
  input  logic [ID_W-1:0]   io_axi_b_payload_id,
  input  logic [1:0]        io_axi_b_payload_resp,
  input  logic              io_axi_r_valid,
  output logic              io_axi_r_ready,
  input  logic [DATA_W-1:0] io_axi_r_payload_data,
  input  logic [ID_W-1:0]   io_axi_r_payload_id,
  input  logic [1:0]        io_axi_r_payload_resp,
  input  logic              io_axi_r_payload_last
);

  localparam logic [7:0]        LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(4 * BURST_LEN);

  state_t            state, state_next;
  logic [15:0]       burst_cnt;
  logic [7:0]        beat_cnt;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       err_cnt;
  logic              pass_q;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] pattern;
  logic              w_hs, b_hs, r_hs;
  logic              last_beat, last_burst, b_bad, r_bad;

  assign beat_addr  = addr + ADDR_W'({beat_cnt, 2'b00});
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign w_hs       = io_axi_w_valid & io_axi_w_ready;
  assign b_hs       = io_axi_b_valid & io_axi_b_ready;
  assign r_hs       = io_axi_r_valid & io_axi_r_ready;
  assign b_bad      = (io_axi_b_payload_resp != RESP_OKAY) || (io_axi_b_payload_id != ID);
  assign r_bad      = (io_axi_r_payload_data != pattern) || (io_axi_r_payload_resp != RESP_OKAY) ||
                      (io_axi_r_payload_id != ID) || (io_axi_r_payload_last != last_beat);

  axi4_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .beat_addr (beat_addr),
    .data      (pattern)
  );

  // Command and write payloads come straight from registers, so they stay stable while stalled.
  assign io_axi_arw_payload_addr  = addr;
  assign io_axi_arw_payload_id    = ID;
  assign io_axi_arw_payload_len   = LAST_BEAT;
  assign io_axi_arw_payload_size  = SIZE_4B;
  assign io_axi_arw_payload_burst = BURST_INCR;
  assign io_axi_w_payload_data    = pattern;
  assign io_axi_w_payload_strb    = 4'hF;
  assign io_axi_w_payload_last    = last_beat;
  assign error_count              = err_cnt;
  assign pass                     = (state == ST_FIN) ? (err_cnt == 16'd0) : pass_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first; a path that skipped one would infer a latch.
    state_next               = state;
    busy                     = 1'b1;
    done                     = 1'b0;
    io_axi_arw_valid         = 1'b0;
    io_axi_arw_payload_write = 1'b0;
    io_axi_w_valid           = 1'b0;
    io_axi_b_ready           = 1'b0;
    io_axi_r_ready           = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_WR_CMD;
      end
      ST_WR_CMD: begin
        io_axi_arw_valid         = 1'b1;
        io_axi_arw_payload_write = 1'b1;
        if (io_axi_arw_ready) state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        io_axi_w_valid = 1'b1;
        if (io_axi_w_ready && last_beat) state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        io_axi_b_ready = 1'b1;
        if (io_axi_b_valid) state_next = last_burst ? ST_RD_CMD : ST_WR_CMD;
      end
      ST_RD_CMD: begin
        io_axi_arw_valid = 1'b1;
        if (io_axi_arw_ready) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        io_axi_r_ready = 1'b1;
        if (io_axi_r_valid && last_beat) state_next = last_burst ? ST_FIN : ST_RD_CMD;
      end
      ST_FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Burst/beat counters, address walk, error accounting and the held pass flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
      addr      <= BASE_ADDR;
      err_cnt   <= '0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            burst_cnt <= '0;
            beat_cnt  <= '0;
            addr      <= BASE_ADDR;
            err_cnt   <= '0;
            pass_q    <= 1'b0;
          end
        end
        ST_WR_DATA: begin
          if (w_hs) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
        end
        ST_WR_RESP: begin
          if (b_hs) begin
            if (b_bad) err_cnt <= sat_inc(err_cnt);
            if (last_burst) begin
              burst_cnt <= '0;
              addr      <= BASE_ADDR;
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
              addr      <= addr + BURST_STEP;
            end
          end
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            if (r_bad) err_cnt <= sat_inc(err_cnt);
            if (last_beat) begin
              beat_cnt <= 8'd0;
              if (!last_burst) begin
                burst_cnt <= burst_cnt + 16'd1;
                addr      <= addr + BURST_STEP;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_FIN: pass_q <= (err_cnt == 16'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_shared_traffic_gen.sv
// Scoreboard bench: a randomized memory slave with fault injection, expected
// commands/beats/results queued at start, checked by an independent monitor.
module tb_axi4_shared_traffic_gen;

  localparam int                ADDR_W     = 25;
  localparam int                DATA_W     = 32;
  localparam int                ID_W       = 2;
  localparam logic [ID_W-1:0]   ID         = 2'd1;
  localparam logic [ADDR_W-1:0] BASE_ADDR  = 25'h1FF_FFE0;
  localparam int                BURST_LEN  = 8;
  localparam int                NUM_BURSTS = 4;
  localparam logic [31:0]       SEED       = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass;
  logic [15:0] error_count;
  logic arw_valid, arw_ready = 1'b0, arw_write;
  logic [ADDR_W-1:0] arw_addr;
  logic [ID_W-1:0] arw_id;
  logic [7:0] arw_len;
  logic [2:0] arw_size;
  logic [1:0] arw_burst;
  logic w_valid, w_ready = 1'b0, w_last;
  logic [DATA_W-1:0] w_data;
  logic [3:0] w_strb;
  logic b_valid = 1'b0, b_ready;
  logic [ID_W-1:0] b_id = '0;
  logic [1:0] b_resp = '0;
  logic r_valid = 1'b0, r_ready, r_last = 1'b0;
  logic [DATA_W-1:0] r_data = '0;
  logic [ID_W-1:0] r_id = '0;
  logic [1:0] r_resp = '0;

  axi4_shared_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ID(ID), .BASE_ADDR(BASE_ADDR),
    .BURST_LEN(BURST_LEN), .NUM_BURSTS(NUM_BURSTS), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count),
    .io_axi_arw_valid(arw_valid), .io_axi_arw_ready(arw_ready),
    .io_axi_arw_payload_addr(arw_addr), .io_axi_arw_payload_id(arw_id),
    .io_axi_arw_payload_len(arw_len), .io_axi_arw_payload_size(arw_size),
    .io_axi_arw_payload_burst(arw_burst), .io_axi_arw_payload_write(arw_write),
    .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready), .io_axi_w_payload_data(w_data),
    .io_axi_w_payload_strb(w_strb), .io_axi_w_payload_last(w_last),
    .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready), .io_axi_b_payload_id(b_id),
    .io_axi_b_payload_resp(b_resp),
    .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready), .io_axi_r_payload_data(r_data),
    .io_axi_r_payload_id(r_id), .io_axi_r_payload_resp(r_resp), .io_axi_r_payload_last(r_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic write; } arw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;
  typedef struct { logic pass; logic [15:0] errs; } res_t;

  arw_t arw_q[$];
  w_t   w_q[$];
  res_t res_q[$];
  logic [31:0] mem [logic [ADDR_W-1:0]];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int w_hs_cnt = 0;
  int ready_pct = 100;
  int flip_burst = -1, flip_beat = -1, bresp_burst = -1, lastf_burst = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
    return SEED + 32'(a);
  endfunction

  function automatic int bidx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return int'(off) / (4 * BURST_LEN);
  endfunction

  function automatic bit roll();
    return $urandom_range(99, 0) < ready_pct;
  endfunction

  // Reference model: the whole pass derived from the address/pattern rules and the fault plan.
  task automatic push_expected(output logic ep, output logic [15:0] ee);
    int errs = 0;
    logic [ADDR_W-1:0] a;
    for (int b = 0; b < NUM_BURSTS; b++) begin
      a = BASE_ADDR + ADDR_W'(b * 4 * BURST_LEN);
      arw_q.push_back('{a, 1'b1});
      for (int k = 0; k < BURST_LEN; k++)
        w_q.push_back('{pat(a + ADDR_W'(4 * k)), k == BURST_LEN - 1});
      if (b == bresp_burst) errs++;
    end
    for (int b = 0; b < NUM_BURSTS; b++) begin
      a = BASE_ADDR + ADDR_W'(b * 4 * BURST_LEN);
      arw_q.push_back('{a, 1'b0});
      for (int k = 0; k < BURST_LEN; k++)
        if ((b == flip_burst && k == flip_beat) ||
            (b == lastf_burst && (k == 5 || k == BURST_LEN - 1))) errs++;
    end
    ep = (errs == 0);
    ee = 16'(errs);
    res_q.push_back('{ep, ee});
  endtask

  // Memory slave with random backpressure and planned faults.
  initial begin : slave
    logic hs_arw, hs_w, hs_b, hs_r, rs, c_write;
    logic [ADDR_W-1:0] c_addr, wa, ra, a;
    logic [7:0] c_len;
    logic [31:0] c_wdata, d;
    int wbeat, rbeat, rlen;
    bit b_pend, r_act;
    wa = '0; ra = '0; wbeat = 0; rbeat = 0; rlen = 1; b_pend = 0; r_act = 0;
    forever begin
      @(negedge clk);
      rs = reset;
      hs_arw = arw_valid && arw_ready;
      hs_w = w_valid && w_ready;
      hs_b = b_valid && b_ready;
      hs_r = r_valid && r_ready;
      c_addr = arw_addr; c_write = arw_write; c_len = arw_len; c_wdata = w_data;
      @(posedge clk);
      #1;
      if (rs) begin
        b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0;
        arw_ready = 0; w_ready = 0; b_valid = 0; r_valid = 0;
      end else begin
        if (hs_arw) begin
          if (c_write) begin wa = c_addr; wbeat = 0; end
          else begin ra = c_addr; rbeat = 0; rlen = int'(c_len) + 1; r_act = 1; end
        end
        if (hs_w) begin
          mem[wa + ADDR_W'(4 * wbeat)] = c_wdata;
          wbeat++;
          if (wbeat == BURST_LEN) b_pend = 1;
        end
        if (hs_b) b_pend = 0;
        if (hs_r) begin
          rbeat++;
          if (rbeat == rlen) r_act = 0;
        end
        arw_ready = roll();
        w_ready = roll();
        if (!(b_valid && !hs_b)) b_valid = b_pend && roll();
        b_id = ID;
        b_resp = (bidx(wa) == bresp_burst) ? 2'b10 : 2'b00;
        if (!(r_valid && !hs_r)) r_valid = r_act && roll();
        if (r_act) begin
          a = ra + ADDR_W'(4 * rbeat);
          d = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
          if (bidx(ra) == flip_burst && rbeat == flip_beat) d = d ^ 32'h1;
          r_data = d;
          r_id = ID;
          r_resp = 2'b00;
          r_last = (bidx(ra) == lastf_burst) ? (rbeat == 5) : (rbeat == rlen - 1);
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queue heads.
  initial begin : monitor
    arw_t ea;
    w_t ew;
    res_t er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (arw_valid) begin
          if (arw_q.size() == 0) check("arw_unexpected", arw_valid, 0);
          else begin
            ea = arw_q[0];
            check("arw", {arw_addr, arw_write, arw_id, arw_len, arw_size, arw_burst},
                  {ea.addr, ea.write, ID, 8'(BURST_LEN - 1), 3'b010, 2'b01});
            if (arw_ready) void'(arw_q.pop_front());
          end
        end
        if (w_valid) begin
          if (w_ready) w_hs_cnt++;
          if (w_q.size() == 0) check("w_unexpected", w_valid, 0);
          else begin
            ew = w_q[0];
            check("w_beat", {w_data, w_last, w_strb}, {ew.data, ew.last, 4'hF});
            if (w_ready) void'(w_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          if (res_q.size() == 0) check("done_unexpected", done, 0);
          else begin
            er = res_q.pop_front();
            check("done_result", {busy, pass, error_count}, {1'b0, er.pass, er.errs});
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, {arw_valid, w_valid, b_ready, r_ready, busy, done, pass, error_count}, '0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_pass(input string name, input bit poke_start);
    int d0, cyc;
    logic ep;
    logic [15:0] ee;
    d0 = done_cnt;
    cyc = 0;
    push_expected(ep, ee);
    pulse_start();
    check({name, "_start"}, {busy, arw_valid, pass, error_count}, {1'b1, 1'b1, 1'b0, 16'd0});
    if (poke_start) begin
      repeat (20) @(posedge clk);
      #1;
      pulse_start();
    end
    while (done_cnt == d0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_single_done"}, done_cnt - d0, 1);
    check({name, "_held"}, {busy, done, pass, error_count}, {1'b0, 1'b0, ep, ee});
    check({name, "_drained"}, arw_q.size() + w_q.size() + res_q.size(), 0);
  endtask

  task automatic clear_faults();
    flip_burst = -1; flip_beat = -1; bresp_burst = -1; lastf_burst = -1;
  endtask

  initial begin : stimulus
    int cyc, w0;
    logic ep;
    logic [15:0] ee;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle_after_reset");

    ready_pct = 100; run_pass("ideal", 0);
    ready_pct = 30;  run_pass("backpressure", 1);
    flip_burst = 2; flip_beat = 3; run_pass("flip_bit", 0);
    bresp_burst = 0; run_pass("flip_and_bresp", 0);
    clear_faults(); lastf_burst = 0; run_pass("late_last", 0);
    flip_burst = 0; flip_beat = 5; run_pass("double_fault_beat", 0);
    clear_faults();

    // Reset in the middle of the first write burst.
    w0 = w_hs_cnt;
    cyc = 0;
    push_expected(ep, ee);
    pulse_start();
    while (w_hs_cnt < w0 + 4 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_reset_reached_beat4", w_hs_cnt >= w0 + 4, 1);
    reset = 1'b1;
    arw_q.delete(); w_q.delete(); res_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("mid_reset_outputs");
    repeat (3) @(posedge clk);
    #1;
    run_pass("after_reset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
